// File: rtl/common_pkg.sv
// Common core-wide scalar types: machine word, 64-bit counters and
// architectural register addresses.
package common_pkg;

    localparam int XLEN      = 64;
    localparam int NREG_BITS = 5;

    typedef logic [XLEN-1:0]      word_t;
    typedef logic [63:0]          u64;
    typedef logic [NREG_BITS-1:0] creg_addr_t;

endpackage

// File: rtl/writeback_stage_pkg.sv
// Pipe bundles shared between the memory and writeback stages, plus the
// load-lane alignment helper.
package writeback_stage_pkg;

    import common_pkg::*;

    typedef enum logic [1:0] {
        LS_B = 2'd0,
        LS_H = 2'd1,
        LS_W = 2'd2,
        LS_D = 2'd3
    } lsize_t;

    typedef struct packed {
        u64         pc;
        creg_addr_t rd;
        logic       wen;
        logic       is_load;
        lsize_t     lsize;
        logic       lunsigned;
        logic [2:0] addr_lo;
        word_t      result;
    } mem_wb_t;

    typedef struct packed {
        logic       valid;
        u64         pc;
        creg_addr_t rd;
        logic       wen;
        word_t      data;
    } wb_entry_t;

    // Misaligned accesses are aligned down to the access size.
    function automatic logic [2:0] lane_offset(
        input logic [2:0] addr_lo,
        input lsize_t     lsize
    );
        logic [2:0] off;
        off = addr_lo;
        unique case (lsize)
            LS_B: off = addr_lo;
            LS_H: off = {addr_lo[2:1], 1'b0};
            LS_W: off = {addr_lo[2], 2'b00};
            LS_D: off = 3'b000;
            default: off = 3'b000;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Combinational load formatter: picks the lane out of the raw doubleword
// and sign- or zero-extends it to a full word.
module load_extend
    import common_pkg::*;
    import writeback_stage_pkg::*;
(
    input  word_t      raw_i,
    input  logic [2:0] addr_lo_i,
    input  lsize_t     lsize_i,
    input  logic       unsigned_i,
    output word_t      data_o
);

    logic [2:0] off;
    word_t      lane;

    always_comb begin
        off    = lane_offset(addr_lo_i, lsize_i);
        lane   = raw_i >> {off, 3'b000};
        data_o = raw_i;
        unique case (lsize_i)
            LS_B: data_o = unsigned_i ? {56'd0, lane[7:0]}
                                      : {{56{lane[7]}}, lane[7:0]};
            LS_H: data_o = unsigned_i ? {48'd0, lane[15:0]}
                                      : {{48{lane[15]}}, lane[15:0]};
            LS_W: data_o = unsigned_i ? {32'd0, lane[31:0]}
                                      : {{32{lane[31]}}, lane[31:0]};
            LS_D: data_o = raw_i;
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: one-entry holding register feeding the RF write port,
// decode forwarding tap and instret. Optional WB_COMMIT_TRACE_EN trace port.
module writeback_stage
    import common_pkg::*;
    import writeback_stage_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       mem_valid,
    output logic       mem_ready,
    input  u64         mem_pc,
    input  creg_addr_t mem_rd,
    input  logic       mem_wen,
    input  logic       mem_is_load,
    input  lsize_t     mem_lsize,
    input  logic       mem_lunsigned,
    input  logic [2:0] mem_addr_lo,
    input  word_t      mem_result,
    output logic       rf_wen,
    output creg_addr_t rf_wa,
    output word_t      rf_wd,
    output logic       fwd_valid,
    output creg_addr_t fwd_rd,
    output word_t      fwd_data,
    output u64         instret
`ifdef WB_COMMIT_TRACE_EN
    ,
    output logic       trace_valid,
    input  logic       trace_ready,
    output u64         trace_pc,
    output creg_addr_t trace_rd,
    output logic       trace_wen,
    output word_t      trace_data
`endif
);

    mem_wb_t   mem_pkt;
    wb_entry_t entry_q, entry_d;
    u64        instret_q, instret_d;
    word_t     ld_data;
    logic      retire;
    logic      fire;
    logic      pend_wr;

    always_comb begin
        mem_pkt           = '0;
        mem_pkt.pc        = mem_pc;
        mem_pkt.rd        = mem_rd;
        mem_pkt.wen       = mem_wen;
        mem_pkt.is_load   = mem_is_load;
        mem_pkt.lsize     = mem_lsize;
        mem_pkt.lunsigned = mem_lunsigned;
        mem_pkt.addr_lo   = mem_addr_lo;
        mem_pkt.result    = mem_result;
    end

    load_extend u_load_extend (
        .raw_i      (mem_pkt.result),
        .addr_lo_i  (mem_pkt.addr_lo),
        .lsize_i    (mem_pkt.lsize),
        .unsigned_i (mem_pkt.lunsigned),
        .data_o     (ld_data)
    );

`ifdef WB_COMMIT_TRACE_EN
    assign retire      = entry_q.valid && trace_ready;
    assign trace_valid = entry_q.valid;
    assign trace_pc    = entry_q.pc;
    assign trace_rd    = entry_q.rd;
    assign trace_wen   = entry_q.wen;
    assign trace_data  = entry_q.data;
`else
    logic unused_pc;
    assign retire    = entry_q.valid;
    assign unused_pc = ^entry_q.pc;
`endif

    assign mem_ready = !entry_q.valid || retire;
    assign fire      = mem_valid && mem_ready;

    // Old entry retires and new one loads in the same cycle: no bubble.
    always_comb begin
        entry_d = entry_q;
        if (fire) begin
            entry_d.valid = 1'b1;
            entry_d.pc    = mem_pkt.pc;
            entry_d.rd    = mem_pkt.rd;
            entry_d.wen   = mem_pkt.wen;
            entry_d.data  = mem_pkt.is_load ? ld_data : mem_pkt.result;
        end else if (retire) begin
            entry_d.valid = 1'b0;
        end
        instret_d = retire ? instret_q + 64'd1 : instret_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry_q   <= '0;
            instret_q <= '0;
        end else begin
            entry_q   <= entry_d;
            instret_q <= instret_d;
        end
    end

    assign pend_wr   = entry_q.wen && (entry_q.rd != '0);
    assign rf_wen    = retire && pend_wr;
    assign rf_wa     = entry_q.rd;
    assign rf_wd     = entry_q.data;
    assign fwd_valid = entry_q.valid && pend_wr;
    assign fwd_rd    = entry_q.rd;
    assign fwd_data  = entry_q.data;
    assign instret   = instret_q;

endmodule
